// File: rtl/rgb_fade_driver.sv
// Red -> green -> blue PWM breathing driver for the board's RGB LED.
// Each colour fades 0 -> 255 -> 0 in steps of STEP_TICKS clocks.
module rgb_fade_driver #(
    parameter int PWM_DIV    = 78,
    parameter int STEP_TICKS = 40000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       hold,
    output logic       redled,
    output logic       greenled,
    output logic       blueled,
    output logic [7:0] level,
    output logic [2:0] phase,
    output logic       cycle_done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        R_UP = 3'd1,
        R_DN = 3'd2,
        G_UP = 3'd3,
        G_DN = 3'd4,
        B_UP = 3'd5,
        B_DN = 3'd6
    } state_t;

    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int STC_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PWM_DIV - 1);
    localparam logic [STC_W-1:0] STC_MAX = STC_W'(STEP_TICKS - 1);

    logic [PRE_W-1:0] pre;
    logic [7:0]       pwm_cnt;
    logic [STC_W-1:0] stc;
    logic             step;
    state_t           state, state_n;
    logic [7:0]       level_r, level_n;
    logic             done_r, done_n;
    logic             led_r, led_g, led_b;
    logic             raw;

    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update together from the values seen before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre     <= '0;
            pwm_cnt <= 8'd0;
        end else if (pre == PRE_MAX) begin
            pre     <= '0;
            pwm_cnt <= pwm_cnt + 8'd1;
        end else begin
            pre     <= pre + 1'b1;
        end
    end

    // The step timer restarts whenever the sequencer is (re)started.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stc <= '0;
        end else if (!en || state == IDLE) begin
            stc <= '0;
        end else if (!hold) begin
            stc <= (stc == STC_MAX) ? '0 : stc + 1'b1;
        end
    end

    assign step = en && !hold && (state != IDLE) && (stc == STC_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            level_r <= 8'd0;
            done_r  <= 1'b0;
        end else begin
            state   <= state_n;
            level_r <= level_n;
            done_r  <= done_n;
        end
    end

    // NOTE: defaults first, so no path through the case leaves a variable
    // unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        level_n = level_r;
        done_n  = 1'b0;
        if (!en) begin
            state_n = IDLE;
            level_n = 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = R_UP;
                    level_n = 8'd0;
                end
                R_UP, G_UP, B_UP: begin
                    if (step) begin
                        if (level_r == 8'd255) state_n = state_t'(state + 3'd1);
                        else                   level_n = level_r + 8'd1;
                    end
                end
                R_DN, G_DN, B_DN: begin
                    if (step) begin
                        if (level_r == 8'd0) begin
                            state_n = (state == B_DN) ? R_UP : state_t'(state + 3'd1);
                            done_n  = (state == B_DN);
                        end else begin
                            level_n = level_r - 8'd1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    level_n = 8'd0;
                end
            endcase
        end
    end

    // Gating with en blanks the LEDs on the same edge the sequencer drops to IDLE.
    assign raw = en && (pwm_cnt < level_r);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_r <= 1'b0;
            led_g <= 1'b0;
            led_b <= 1'b0;
        end else begin
            led_r <= raw && (state == R_UP || state == R_DN);
            led_g <= raw && (state == G_UP || state == G_DN);
            led_b <= raw && (state == B_UP || state == B_DN);
        end
    end

    assign redled     = led_r ^ ACTIVE_LOW;
    assign greenled   = led_g ^ ACTIVE_LOW;
    assign blueled    = led_b ^ ACTIVE_LOW;
    assign level      = level_r;
    assign phase      = state;
    assign cycle_done = done_r;

endmodule

// File: tb/tb_rgb_fade_driver.sv
// Scoreboard bench for rgb_fade_driver: two instances (active-high and
// active-low with a slower prescaler) checked against a step-index model.
module tb_rgb_fade_driver;

    localparam int DIV_A = 1;
    localparam int DIV_B = 3;
    localparam int ST    = 4;
    localparam int CYC   = 1536;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       hold = 1'b0;
    logic       red_a, green_a, blue_a, done_a;
    logic       red_b, green_b, blue_b, done_b;
    logic [7:0] level_a, level_b;
    logic [2:0] phase_a, phase_b;

    rgb_fade_driver #(.PWM_DIV(DIV_A), .STEP_TICKS(ST), .ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .hold(hold),
        .redled(red_a), .greenled(green_a), .blueled(blue_a),
        .level(level_a), .phase(phase_a), .cycle_done(done_a)
    );

    rgb_fade_driver #(.PWM_DIV(DIV_B), .STEP_TICKS(ST), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .hold(hold),
        .redled(red_b), .greenled(green_b), .blueled(blue_b),
        .level(level_b), .phase(phase_b), .cycle_done(done_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] phase;
        logic [7:0] level;
        logic       done;
        logic [2:0] led_a;
        logic [2:0] led_b;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Model: the whole R-G-B sequence is a step index k in 0..1535.
    bit         m_active;
    int         m_k, m_t, m_n;
    exp_t       m_e;
    logic [2:0] m_la, m_lb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_phase();
        if (!m_active) return 0;
        return 1 + 2 * (m_k / 512) + (((m_k % 512) >= 256) ? 1 : 0);
    endfunction

    function automatic int m_level();
        int w;
        w = m_k % 512;
        if (!m_active) return 0;
        return (w < 256) ? w : 511 - w;
    endfunction

    function automatic logic [2:0] m_led(input int div, input bit inv);
        int         pwm;
        logic [2:0] v;
        pwm = (m_n / div) % 256;
        v = (en && m_active && pwm < m_level()) ? (3'b100 >> (m_k / 512)) : 3'b000;
        return v ^ {3{inv}};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_k = 0;
            m_t = 0;
            m_n = 0;
            sb.delete();
        end else begin
            m_la = m_led(DIV_A, 1'b0);
            m_lb = m_led(DIV_B, 1'b1);
            m_e.done = 1'b0;
            if (!en) begin
                m_active = 1'b0;
                m_k = 0;
                m_t = 0;
            end else if (!m_active) begin
                m_active = 1'b1;
                m_k = 0;
                m_t = 0;
            end else if (!hold) begin
                m_t++;
                if (m_t == ST) begin
                    m_t = 0;
                    m_k = (m_k + 1) % CYC;
                    m_e.done = (m_k == 0);
                end
            end
            m_n++;
            m_e.phase = 3'(m_phase());
            m_e.level = 8'(m_level());
            m_e.led_a = m_la;
            m_e.led_b = m_lb;
            sb.push_back(m_e);
        end
    end

    always @(posedge clk) begin
        exp_t g;
        #1;
        if (!rst) begin
            if (sb.size() == 0) begin
                check("sb_empty", 32'd0, 32'd1);
            end else begin
                g = sb.pop_front();
                check("phase_a", phase_a, g.phase);
                check("level_a", level_a, g.level);
                check("done_a", done_a, g.done);
                check("leds_a", {red_a, green_a, blue_a}, g.led_a);
                check("phase_b", phase_b, g.phase);
                check("level_b", level_b, g.level);
                check("done_b", done_b, g.done);
                check("leds_b", {red_b, green_b, blue_b}, g.led_b);
            end
        end
    end

    task automatic wait_for(input int ph, input int lv, input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            @(negedge clk);
            if (m_phase() == ph && m_level() == lv) break;
        end
        if (i == limit) begin
            checks++;
            errors++;
            $display("FAIL wait_for: phase %0d level %0d not reached in %0d clks", ph, lv, limit);
        end
    endtask

    task automatic count_ones(input int n, output int ra, output int ga, output int ba,
                              output int rb, output int gb, output int bb);
        ra = 0; ga = 0; ba = 0; rb = 0; gb = 0; bb = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            ra += int'(red_a);  ga += int'(green_a); ba += int'(blue_a);
            rb += int'(red_b);  gb += int'(green_b); bb += int'(blue_b);
        end
    endtask

    int ra, ga, ba, rb, gb, bb;
    int cnt, first_done, second_done, pulses;

    initial begin
        // Reset asserted in the middle of the low clock phase.
        #3 rst = 1'b1;
        #1;
        check("rst_leds_a", {red_a, green_a, blue_a}, 3'b000);
        check("rst_leds_b", {red_b, green_b, blue_b}, 3'b111);
        check("rst_phase", phase_a, 3'd0);
        check("rst_level", level_a, 8'd0);
        check("rst_done", done_a, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (1000) @(negedge clk);

        // Two full cycles: cycle_done timing measured from en rising.
        en = 1'b1;
        cnt = 0; first_done = 0; second_done = 0; pulses = 0;
        repeat (2 * 6144 + 50) begin
            @(posedge clk);
            #1;
            cnt++;
            if (done_a) begin
                pulses++;
                if (pulses == 1) first_done = cnt;
                if (pulses == 2) second_done = cnt;
            end
        end
        check("done_pulses", pulses, 2);
        check("first_done_at", first_done, 6145);
        check("done_interval", second_done - first_done, 6144);

        // Randomised en/hold segments.
        for (int s = 0; s < 20; s++) begin
            int r;
            int len;
            r = $urandom_range(0, 7);
            len = $urandom_range(50, 1500);
            @(negedge clk);
            en = (r != 0);
            hold = (r == 1 || r == 2);
            repeat (len) @(negedge clk);
        end
        hold = 1'b0;
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;

        // Level 64 in R_UP frozen: 64/256 duty on red only.
        wait_for(1, 64, 2000);
        hold = 1'b1;
        repeat (8) @(negedge clk);
        count_ones(768, ra, ga, ba, rb, gb, bb);
        check("duty64_red_a", ra, 3 * 64);
        check("duty64_green_a", ga, 0);
        check("duty64_blue_a", ba, 0);
        check("duty64_red_b_high", rb, 768 - 192);
        check("duty64_green_b_high", gb, 768);
        @(negedge clk);
        hold = 1'b0;

        // Hold in G_DN at level 100 for 5000 clks.
        wait_for(4, 100, 10000);
        hold = 1'b1;
        repeat (5000) @(negedge clk);
        check("hold_level", level_a, 8'd100);
        check("hold_phase", phase_a, 3'd4);
        count_ones(256, ra, ga, ba, rb, gb, bb);
        check("hold_green_duty", ga, 100);
        @(negedge clk);
        hold = 1'b0;
        repeat (4) @(negedge clk);
        check("release_level", level_a, 8'd99);

        // Enable drop in B_UP at level 200.
        wait_for(5, 200, 4000);
        en = 1'b0;
        @(negedge clk);
        check("drop_phase", phase_a, 3'd0);
        check("drop_level", level_a, 8'd0);
        check("drop_leds_a", {red_a, green_a, blue_a}, 3'b000);
        check("drop_leds_b", {red_b, green_b, blue_b}, 3'b111);
        en = 1'b1;
        @(negedge clk);
        check("reen_phase", phase_a, 3'd1);
        check("reen_level", level_a, 8'd0);

        // Level 255: on 255 of every 256 counts (low for active-low).
        wait_for(1, 255, 2000);
        hold = 1'b1;
        repeat (2) @(negedge clk);
        count_ones(768, ra, ga, ba, rb, gb, bb);
        check("duty255_red_a", ra, 3 * 255);
        check("duty255_red_b_high", rb, 3);
        @(negedge clk);
        hold = 1'b0;

        // R_DN at level 0: constant off.
        wait_for(2, 0, 2000);
        hold = 1'b1;
        count_ones(256, ra, ga, ba, rb, gb, bb);
        check("dn0_red_a", ra, 0);
        check("dn0_red_b_high", rb, 256);
        @(negedge clk);
        hold = 1'b0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgb_fade_driver.md
Name: rgb_fade_driver

Overview:
- Downstream LED output stage for the Vaman board, clocked from the eFPGA fabric system clock (Sys_Clk0).
- Drives the red, green and blue LED pins with an 8-bit PWM "breathing" sequence that goes red, then green, then blue, then repeats.
- Replaces a raw toggle on a single pin with brightness-controlled fades.
- Exposes enable and hold controls plus status outputs, so a later controller can sequence it.

Parameters:
- PWM_DIV, 78, clk cycles per PWM count increment; one PWM period = 256*PWM_DIV clocks. Legal range >=1.
- STEP_TICKS, 40000, clk cycles per fade step. Legal range >=1.
- ACTIVE_LOW, 0, 1 inverts all three LED outputs. The "off" level is 1 when set.

Ports:
- clk  input  1  fabric system clock (Sys_Clk0)
- rst  input  1  asynchronous, active-high reset
- en  input  1  1 = run the sequence; 0 = LEDs off, sequencer idle
- hold  input  1  1 = freeze the fade level and state; PWM keeps running
- redled  output  1  red LED drive
- greenled  output  1  green LED drive
- blueled  output  1  blue LED drive
- level  output  8  current brightness of the active colour
- phase  output  3  FSM state encoding: 0 IDLE, 1 R_UP, 2 R_DN, 3 G_UP, 4 G_DN, 5 B_UP, 6 B_DN
- cycle_done  output  1  one-clock pulse at the end of each full R-G-B cycle

Behaviour:
- Reset (async assert, released synchronously to clk):
  - All counters = 0, level = 0, phase = IDLE, cycle_done = 0.
  - All LED outputs at the off level (0, or 1 if ACTIVE_LOW).
- Prescaler:
  - pre counts 0..PWM_DIV-1 and wraps.
  - pwm_cnt (8 bit) increments when pre == PWM_DIV-1, wrapping 255 -> 0.
- Step timer:
  - stc counts 0..STEP_TICKS-1.
  - step is asserted for one clk when stc == STEP_TICKS-1 and hold == 0.
  - When hold == 1, stc freezes.
- FSM:
  - IDLE -> R_UP on the first clk with en == 1, with level = 0.
  - UP state on step: if level == 255, go to the matching DN state with level unchanged; otherwise level+1.
  - DN state on step: if level == 0, go to the next colour's UP state (R_DN -> G_UP, G_DN -> B_UP, B_DN -> R_UP); otherwise level-1.
  - B_DN -> R_UP asserts cycle_done for exactly that clk.
  - Each colour takes 512 steps; a full cycle takes 1536 steps = 1536*STEP_TICKS clks.
- en deasserted in any state:
  - Next clk: phase = IDLE, level = 0, stc = 0, LEDs off.
  - Prescaler and pwm_cnt keep running.
  - Re-enable always restarts at R_UP, level 0.
- hold and en together: en has priority. hold only matters when en == 1.
- PWM output:
  - raw = (pwm_cnt < level), routed only to the channel of the current phase. Other channels are off.
  - Outputs are registered (1 clk after pwm_cnt/level), then XORed with ACTIVE_LOW.
  - level 0 gives a constant off output; level 255 gives on for 255 of every 256 PWM counts.
- Width and arithmetic:
  - level never wraps; saturation is handled by the FSM transitions.
  - pre and stc are sized by $clog2 of their parameter, minimum 1 bit.

Test Plan:
- Reset and idle: PWM_DIV=1, STEP_TICKS=4, ACTIVE_LOW=0; assert rst mid-clock, en=0 -> all LEDs 0, phase 0, level 0 immediately and for 1000 clks after release.
- Full cycle timing: same parameters, en=1 -> phase goes 1..6 in order; level peaks at 255 in each UP state; cycle_done pulses exactly once per 6144 clks; the first pulse arrives 6144 clks (+1 IDLE exit) after en rises.
- PWM duty: force level to 64 during R_UP by hold after 64 steps -> redled high for exactly 64 of every 256 clks; greenled and blueled stay 0.
- Hold freeze: hold=1 for 5000 clks in G_DN at level 100 -> level and phase unchanged and PWM still toggles; after release, level reaches 99 after 4 clks.
- Enable drop mid-run: en=0 in B_UP at level 200 -> next clk phase 0, level 0, all LEDs off; en=1 again -> R_UP from level 0.
- Polarity and boundaries: ACTIVE_LOW=1 -> all LEDs 1 in reset and IDLE; at level 255 the active LED is low 255 of every 256 clks; in the DN state at level 0 the LED stays constant high.
